// File: rtl/seq_divider8_pkg.sv
// rtl/seq_divider8_pkg.sv - shared constants and state type for the sequential divider
package seq_divider8_pkg;

  // Operand/result width; the divider runs one iteration per bit
  localparam int DIV_WIDTH = 8;

  // Iteration counter width
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider8_div_step.sv
// rtl/seq_divider8_div_step.sv - one restoring-division step with a single shared subtractor
module seq_divider8_div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic         q_msb,
  input  logic [W-1:0] d,
  output logic [W-1:0] r_next,
  output logic         q_bit
);

  logic [W:0]   t;
  logic [W+1:0] diff;
  logic         borrow;

  // Partial remainder shifted left with the next dividend bit, compared at full
  // W+1 bit width; the extra top bit of diff is the exact borrow out.
  always_comb begin
    t      = {r, q_msb};
    diff   = {1'b0, t} - {2'b00, d};
    borrow = diff[W+1];
    q_bit  = ~borrow;
    r_next = borrow ? t[W-1:0] : diff[W-1:0];
  end

endmodule

// File: rtl/seq_divider8.sv
// rtl/seq_divider8.sv - sequential unsigned restoring divider with start/busy/done handshake
module seq_divider8
  import seq_divider8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int WIDTH = DIV_WIDTH;
  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(WIDTH - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     r_q, r_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic [WIDTH-1:0]     d_q, d_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     step_r;
  logic                 step_qbit;
  logic [WIDTH-1:0]     step_q;

  seq_divider8_div_step #(.W(WIDTH)) u_step (
    .r      (r_q),
    .q_msb  (q_q[WIDTH-1]),
    .d      (d_q),
    .r_next (step_r),
    .q_bit  (step_qbit)
  );

  assign step_q = {q_q[WIDTH-2:0], step_qbit};

  // Next-state logic: accept start in IDLE/DONE, iterate in RUN, publish results on DONE entry
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    q_d         = q_q;
    d_d         = d_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          if (divisor != '0) begin
            d_d     = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            quotient_d  = DBZ_QUOTIENT;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          quotient_d  = step_q;
          remainder_d = step_r;
          dbz_d       = 1'b0;
          state_d     = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
      q_q         <= q_d;
      d_q         <= d_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// tb/tb_seq_divider8.sv - randomized self-checking bench for seq_divider8
module tb_seq_divider8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;

  seq_divider8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Transaction-level reference: cycles left in the current division and the
  // results it must publish, computed with plain / and %.
  int         m_left;
  logic       m_done;
  logic [7:0] m_q, m_r, m_a, m_b;
  logic       m_dbz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_q = 0; m_r = 0; m_dbz = 0; m_a = 0; m_b = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_q = m_a / m_b; m_r = m_a % m_b; m_dbz = 0;
      end
    end else begin
      m_done = 0;
      if (start) begin
        if (divisor == 0) begin
          m_done = 1; m_q = 8'hFF; m_r = dividend; m_dbz = 1;
        end else begin
          m_a = dividend; m_b = divisor; m_left = 8;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the reference
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, (m_left > 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, m_dbz);
    end
  end

  // Waits until done, returning the number of negedges since the start-sampling edge
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                       input logic [7:0] eq, input logic [7:0] er, input logic edbz);
    int n;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom);
    wait_done(n);
    chk("latency", n, exp_lat);
    chk("op_quotient", quotient, eq);
    chk("op_remainder", remainder, er);
    chk("op_dbz", div_by_zero, edbz);
  endtask

  initial begin
    int n;
    int busy_seen;
    int done_seen;
    logic [7:0] a, b;
    rst_n = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    #2;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_dbz", div_by_zero, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Hand-computed anchors
    do_op(8'd100, 8'd7, 9, 8'd14, 8'd2, 1'b0);
    do_op(8'd255, 8'd1, 9, 8'd255, 8'd0, 1'b0);
    do_op(8'd5, 8'd200, 9, 8'd0, 8'd5, 1'b0);
    do_op(8'd200, 8'd200, 9, 8'd1, 8'd0, 1'b0);

    // Divide by zero: one-cycle latency, busy never high
    @(negedge clk);
    dividend = 8'd42; divisor = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("dbz_busy", busy, 0);
    chk("dbz_done", done, 1);
    chk("dbz_quotient", quotient, 8'hFF);
    chk("dbz_remainder", remainder, 42);
    chk("dbz_flag", div_by_zero, 1);

    // Start pulsed mid-run with other operands must be ignored
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (3) begin @(negedge clk); n++; end
    dividend = 8'd50; divisor = 8'd3; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0;
    done_seen = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("ignore_latency", n, 9);
    chk("ignore_quotient", quotient, 14);
    chk("ignore_remainder", remainder, 2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("ignore_single_done", done_seen, 0);

    // Back-to-back: start held through the done cycle
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    dividend = 8'd77; divisor = 8'd9;
    wait_done(n);
    chk("b2b_first_latency", n, 9);
    chk("b2b_first_quotient", quotient, 14);
    chk("b2b_first_remainder", remainder, 2);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_no_gap_busy", busy, 1);
    wait_done(n);
    chk("b2b_second_latency", n, 9);
    chk("b2b_second_quotient", quotient, 8);
    chk("b2b_second_remainder", remainder, 5);

    // Asynchronous reset at step 4 discards the operation
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    busy_seen = 0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("arst_no_done", done_seen, 0);
    chk("arst_no_busy", busy_seen, 0);
    rst_n = 1'b1;
    do_op(8'd13, 8'd4, 9, 8'd3, 8'd1, 1'b0);

    // Randomized operations, including zero divisors and idle gaps
    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      if (b == 0) do_op(a, b, 1, 8'hFF, a, 1'b1);
      else        do_op(a, b, 9, a / b, a % b, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
